// File: rtl/muldiv_sequencer.sv
// Iterative unsigned 32x32 multiplier and restoring divider.
// Each operation retires one bit per cycle and takes 32 cycles; results go to hi/lo.
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  alu_ctrl,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [3:0] CTRL_MUL = 4'd5;
  localparam logic [3:0] CTRL_DIV = 4'd4;

  state_t      state;
  logic [4:0]  cnt;
  logic [63:0] acc;   // MUL: {partial product, remaining multiplier}; DIV: low half holds dividend/quotient
  logic [31:0] opnd;  // multiplicand or divisor
  logic [31:0] rem;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] rem_sh;
  logic [32:0] rem_diff;
  logic [31:0] rem_next;
  logic [31:0] quo_next;

  // NOTE: every variable gets a value on every path here, so no latch can be inferred.
  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next = {mul_sum, acc[31:1]};
    rem_sh   = {rem, acc[31]};
    rem_diff = rem_sh - {1'b0, opnd};
    if (rem_diff[32]) begin
      rem_next = rem_sh[31:0];
      quo_next = {acc[30:0], 1'b0};
    end else begin
      rem_next = rem_diff[31:0];
      quo_next = {acc[30:0], 1'b1};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      acc         <= 64'd0;
      opnd        <= 32'd0;
      rem         <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      // Abort wins over start and completion; results are left untouched.
      state <= IDLE;
      cnt   <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && alu_ctrl == CTRL_MUL) begin
            acc   <= {32'd0, op_b};
            opnd  <= op_a;
            cnt   <= 5'd31;
            busy  <= 1'b1;
            state <= MUL;
          end else if (start && alu_ctrl == CTRL_DIV) begin
            busy <= 1'b1;
            if (op_b == 32'd0) begin
              hi          <= op_a;
              lo          <= 32'hFFFF_FFFF;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= DONE;
            end else begin
              acc   <= {32'd0, op_a};
              opnd  <= op_b;
              rem   <= 32'd0;
              cnt   <= 5'd31;
              state <= DIV;
            end
          end
        end
        MUL: begin
          acc <= mul_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            hi          <= mul_next[63:32];
            lo          <= mul_next[31:0];
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DIV: begin
          acc <= {acc[63:32], quo_next};
          rem <= rem_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            hi          <= rem_next;
            lo          <= quo_next;
            div_by_zero <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomised checks of muldiv_sequencer against a scoreboard of
// expected results computed with the simulator's own arithmetic.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  muldiv_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .alu_ctrl    (alu_ctrl),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;  // rising edges from the accept edge (inclusive) until done is visible
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          t0 = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    if (ctrl == 4'd5) begin
      e.hi = p[63:32]; e.lo = p[31:0]; e.dbz = 1'b0; e.lat = 33;
    end else if (b == 32'd0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.hi = a % b; e.lo = a / b; e.dbz = 1'b0; e.lat = 33;
    end
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept edge.
  task automatic launch(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                        input bit expect_done);
    start    = 1'b1;
    alu_ctrl = ctrl;
    op_a     = a;
    op_b     = b;
    t0       = cyc;
    if (expect_done) sb.push_back(model(ctrl, a, b));
    @(negedge clk);
    start    = 1'b0;
    alu_ctrl = 4'd0;
    op_a     = ~a;
    op_b     = b ^ 32'h5A5A_A5A5;
  endtask

  task automatic wait_done(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      check({tag, "_timeout"}, {63'd0, done}, 64'd1);
    end else if (sb.size() == 0) begin
      check({tag, "_unexpected_done"}, {63'd0, done}, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_latency"}, 64'(cyc - t0), 64'(e.lat));
      check({tag, "_hi"}, {32'd0, hi}, {32'd0, e.hi});
      check({tag, "_lo"}, {32'd0, lo}, {32'd0, e.lo});
      check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, e.dbz});
      check({tag, "_busy_in_done"}, {63'd0, busy}, 64'd1);
      last_hi = e.hi;
      last_lo = e.lo;
      @(negedge clk);
      check({tag, "_done_one_cycle"}, {63'd0, done}, 64'd0);
      check({tag, "_busy_after"}, {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic no_done_for(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;

    rst_n = 1'b0; start = 1'b0; alu_ctrl = 4'd0; op_a = 32'd0; op_b = 32'd0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    rst_n = 1'b1;

    // Accepted on the very first edge after release; a stray start mid-operation is ignored.
    launch(4'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    check("mul_busy_e0", {63'd0, busy}, 64'd1);
    repeat (9) @(negedge clk);
    start = 1'b1; alu_ctrl = 4'd5; op_a = 32'd7; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0; alu_ctrl = 4'd0;
    check("mul_mid_hilo", {hi, lo}, 64'd0);
    check("mul_mid_busy", {63'd0, busy}, 64'd1);
    wait_done("mul_max");
    no_done_for("mul_restart_ignored", 40);

    launch(4'd4, 32'd100, 32'd7, 1'b1);
    wait_done("div_100_7");

    launch(4'd4, 32'h1234_5678, 32'd0, 1'b1);
    wait_done("div_zero");

    launch(4'd4, 32'd9, 32'd3, 1'b1);
    wait_done("div_9_3");

    // Codes other than 5 and 4 belong to the main ALU.
    start = 1'b1; alu_ctrl = 4'd2; op_a = 32'd11; op_b = 32'd13;
    @(negedge clk);
    start = 1'b0; alu_ctrl = 4'd0;
    check("other_busy", {63'd0, busy}, 64'd0);
    no_done_for("other_no_done", 5);
    check("other_hilo", {hi, lo}, {last_hi, last_lo});

    // Reset during the 20th divide iteration.
    launch(4'd4, 32'd1000, 32'd3, 1'b0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    no_done_for("rst_mid_no_resume", 40);
    check("rst_mid_busy_after", {63'd0, busy}, 64'd0);

    // Flush at iteration 10 of 3*5.
    launch(4'd5, 32'd3, 32'd5, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_hilo", {hi, lo}, 64'd0);
    no_done_for("flush_no_done", 40);

    // Flush on the same edge the counter reaches zero.
    launch(4'd5, 32'd3, 32'd5, 1'b0);
    repeat (31) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_last_done", {63'd0, done}, 64'd0);
    check("flush_last_busy", {63'd0, busy}, 64'd0);
    check("flush_last_hilo", {hi, lo}, 64'd0);
    no_done_for("flush_last_no_done", 5);

    launch(4'd5, 32'd6, 32'd7, 1'b1);
    wait_done("mul_6_7");

    for (int i = 0; i < 8; i++) begin
      rc = (i % 2 == 0) ? 4'd5 : 4'd4;
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i == 5) rb = 32'd0;
      launch(rc, ra, rb, 1'b1);
      wait_done($sformatf("rand%0d", i));
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
